// File: rtl/dtpu_infifo_if.sv
// Stream-in and FIFO-out signal bundle for dtpu_infifo.
// The master side drives the stream and pop requests; the slave side is the FIFO.
interface dtpu_infifo_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 16
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tlast;
    logic                  s_axis_tready;
    logic                  infifo_read;
    logic [DATA_WIDTH-1:0] infifo_dout;
    logic                  infifo_last;
    logic                  infifo_is_empty;
    logic                  infifo_almost_full;
    logic [LVL_W-1:0]      level;
    logic                  err_underflow;
    logic                  err_clear;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, infifo_read, err_clear,
        input  s_axis_tready, infifo_dout, infifo_last, infifo_is_empty,
               infifo_almost_full, level, err_underflow
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, infifo_read, err_clear,
        output s_axis_tready, infifo_dout, infifo_last, infifo_is_empty,
               infifo_almost_full, level, err_underflow
    );
endinterface

// File: rtl/dtpu_infifo.sv
// First-word-fall-through input FIFO between the stream DMA and dtpu_core.
// Fill level, ready, empty and almost-full are all registered from one level update.
module dtpu_infifo #(
    parameter int unsigned DATA_WIDTH_FIFO_IN = 64,
    parameter int unsigned DEPTH              = 16,
    parameter int unsigned AFULL_TH           = 12
) (
    input logic          clk,
    input logic          reset,
    dtpu_infifo_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned WORD_W = DATA_WIDTH_FIFO_IN + 1;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              tready_q, tready_d;
    logic              empty_q, empty_d;
    logic              afull_q, afull_d;
    logic              err_q, err_d;
    logic              wr_en, rd_en;
    logic [WORD_W-1:0] head;

    assign wr_en = bus.s_axis_tvalid & tready_q;
    assign rd_en = bus.infifo_read & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (wr_en && !rd_en) level_d = level_q + LVL_W'(1);
        else if (!wr_en && rd_en) level_d = level_q - LVL_W'(1);
        tready_d = (level_d < LVL_W'(DEPTH));
        empty_d  = (level_d == '0);
        afull_d  = (level_d >= LVL_W'(AFULL_TH));
        // A new underflow wins over a same-cycle clear.
        if (bus.infifo_read && empty_q) err_d = 1'b1;
        else if (bus.err_clear)         err_d = 1'b0;
        else                            err_d = err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            tready_q <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            tready_q <= tready_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            err_q    <= err_d;
        end
    end

    // Storage is not reset; the pointers and level alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem_q[wr_ptr_q] <= {bus.s_axis_tlast, bus.s_axis_tdata};
    end

    assign head = empty_q ? '0 : mem_q[rd_ptr_q];

    assign bus.s_axis_tready      = tready_q;
    assign bus.infifo_dout        = head[DATA_WIDTH_FIFO_IN-1:0];
    assign bus.infifo_last        = head[DATA_WIDTH_FIFO_IN];
    assign bus.infifo_is_empty    = empty_q;
    assign bus.infifo_almost_full = afull_q;
    assign bus.level              = level_q;
    assign bus.err_underflow      = err_q;
endmodule

// File: tb/tb_dtpu_infifo.sv
// Bench for dtpu_infifo: directed scenarios plus random traffic against a queue model.
module tb_dtpu_infifo;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFULL = 12;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dtpu_infifo_if #(.DATA_WIDTH(64), .DEPTH(DEPTH)) bus ();

    dtpu_infifo #(.DATA_WIDTH_FIFO_IN(64), .DEPTH(DEPTH), .AFULL_TH(AFULL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model: a queue of {last, data}, plus the registered ready and error flags.
    logic [64:0] mq [$];
    logic        m_ready;
    logic        m_err;

    task automatic cycle(input logic rst, input logic tv, input logic tl,
                         input logic [63:0] td, input logic rd, input logic clr);
        logic wr, rde, uf;
        reset             = rst;
        bus.s_axis_tvalid = tv;
        bus.s_axis_tlast  = tl;
        bus.s_axis_tdata  = td;
        bus.infifo_read   = rd;
        bus.err_clear     = clr;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_ready = 1'b0;
            m_err   = 1'b0;
        end else begin
            wr  = tv && m_ready;
            rde = rd && (mq.size() != 0);
            uf  = rd && (mq.size() == 0);
            if (rde) void'(mq.pop_front());
            if (wr) mq.push_back({tl, td});
            m_ready = (mq.size() < DEPTH);
            m_err   = uf ? 1'b1 : (clr ? 1'b0 : m_err);
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b1, 64'h1234, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 64'h5678, 1'b0, 1'b0);
        checks++; if (bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got=%b exp=0", bus.s_axis_tready); end
        checks++; if (bus.infifo_is_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", bus.infifo_is_empty); end
        checks++; if (bus.level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
        checks++; if (bus.infifo_dout !== 64'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0", bus.infifo_dout); end
        checks++; if (bus.err_underflow !== 1'b0 || bus.infifo_almost_full !== 1'b0) begin errors++; $display("FAIL reset_flags err=%b afull=%b exp=0,0", bus.err_underflow, bus.infifo_almost_full); end
        idle();
        checks++; if (bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL release_tready got=%b exp=1", bus.s_axis_tready); end
    endtask

    task automatic test_single();
        cycle(1'b0, 1'b1, 1'b1, 64'hCAFECAFECAFECAFE, 1'b0, 1'b0);
        checks++; if (bus.infifo_is_empty !== 1'b0) begin errors++; $display("FAIL single_empty got=%b exp=0", bus.infifo_is_empty); end
        checks++; if (bus.infifo_dout !== 64'hCAFECAFECAFECAFE) begin errors++; $display("FAIL single_dout got=%h exp=cafecafecafecafe", bus.infifo_dout); end
        checks++; if (bus.infifo_last !== 1'b1) begin errors++; $display("FAIL single_last got=%b exp=1", bus.infifo_last); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        checks++; if (bus.infifo_is_empty !== 1'b1 || bus.infifo_dout !== 64'h0 || bus.infifo_last !== 1'b0) begin errors++; $display("FAIL single_drain empty=%b dout=%h last=%b exp=1,0,0", bus.infifo_is_empty, bus.infifo_dout, bus.infifo_last); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 64'(i), 1'b0, 1'b0);
            checks++; if (bus.level !== 5'(i + 1)) begin errors++; $display("FAIL fill_level i=%0d got=%0d exp=%0d", i, bus.level, i + 1); end
            checks++; if (bus.infifo_almost_full !== ((i + 1) >= 12)) begin errors++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, bus.infifo_almost_full, (i + 1) >= 12); end
            checks++; if (bus.s_axis_tready !== ((i + 1) < 16)) begin errors++; $display("FAIL fill_tready i=%0d got=%b exp=%b", i, bus.s_axis_tready, (i + 1) < 16); end
        end
        cycle(1'b0, 1'b1, 1'b1, 64'hDEAD, 1'b0, 1'b0);
        checks++; if (bus.level !== 5'd16 || bus.infifo_dout !== 64'd0) begin errors++; $display("FAIL full_hold level=%0d dout=%h exp=16,0", bus.level, bus.infifo_dout); end
        cycle(1'b0, 1'b1, 1'b1, 64'hDEAD, 1'b1, 1'b0);
        checks++; if (bus.infifo_dout !== 64'd1 || bus.level !== 5'd15 || bus.s_axis_tready !== 1'b1) begin errors++; $display("FAIL full_read dout=%h level=%0d tready=%b exp=1,15,1", bus.infifo_dout, bus.level, bus.s_axis_tready); end
        cycle(1'b0, 1'b1, 1'b1, 64'hDEAD, 1'b0, 1'b0);
        checks++; if (bus.level !== 5'd16 || bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL full_refill level=%0d tready=%b exp=16,0", bus.level, bus.s_axis_tready); end
        for (int j = 1; j < 16; j++) begin
            checks++; if (bus.infifo_dout !== 64'(j) || bus.infifo_last !== 1'b0) begin errors++; $display("FAIL drain_order j=%0d got=%h last=%b exp=%0h,0", j, bus.infifo_dout, bus.infifo_last, j); end
            cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        end
        checks++; if (bus.infifo_dout !== 64'hDEAD || bus.infifo_last !== 1'b1) begin errors++; $display("FAIL drain_dead got=%h last=%b exp=dead,1", bus.infifo_dout, bus.infifo_last); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        checks++; if (bus.infifo_is_empty !== 1'b1 || bus.level !== 5'd0) begin errors++; $display("FAIL drain_empty empty=%b level=%0d exp=1,0", bus.infifo_is_empty, bus.level); end
    endtask

    task automatic test_wrap();
        logic [63:0] d;
        cycle(1'b0, 1'b1, 1'b0, 64'h1111, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            d = {$urandom, $urandom};
            cycle(1'b0, 1'b1, 1'b0, d, 1'b1, 1'b0);
            checks++; if (bus.level !== 5'd1 || bus.infifo_is_empty !== 1'b0 || bus.infifo_dout !== d) begin errors++; $display("FAIL wrap i=%0d level=%0d empty=%b dout=%h exp=1,0,%h", i, bus.level, bus.infifo_is_empty, bus.infifo_dout, d); end
        end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic test_underflow();
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        checks++; if (bus.err_underflow !== 1'b1 || bus.level !== 5'd0 || bus.infifo_is_empty !== 1'b1) begin errors++; $display("FAIL uf_set err=%b level=%0d empty=%b exp=1,0,1", bus.err_underflow, bus.level, bus.infifo_is_empty); end
        idle();
        checks++; if (bus.err_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got=%b exp=1", bus.err_underflow); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checks++; if (bus.err_underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got=%b exp=0", bus.err_underflow); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
        checks++; if (bus.err_underflow !== 1'b1) begin errors++; $display("FAIL uf_clear_race got=%b exp=1", bus.err_underflow); end
        // A write after underflow must land at the head: pointers did not move.
        cycle(1'b0, 1'b1, 1'b0, 64'h7777, 1'b0, 1'b1);
        checks++; if (bus.infifo_dout !== 64'h7777 || bus.level !== 5'd1 || bus.err_underflow !== 1'b0) begin errors++; $display("FAIL uf_ptrs dout=%h level=%0d err=%b exp=7777,1,0", bus.infifo_dout, bus.level, bus.err_underflow); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 64'(100 + i), 1'b0, 1'b0);
        checks++; if (bus.level !== 5'd7) begin errors++; $display("FAIL mid_level_pre got=%0d exp=7", bus.level); end
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        checks++; if (bus.level !== 5'd0 || bus.infifo_is_empty !== 1'b1 || bus.s_axis_tready !== 1'b0) begin errors++; $display("FAIL mid_reset level=%0d empty=%b tready=%b exp=0,1,0", bus.level, bus.infifo_is_empty, bus.s_axis_tready); end
        idle();
        cycle(1'b0, 1'b1, 1'b1, 64'hABCD, 1'b0, 1'b0);
        checks++; if (bus.infifo_dout !== 64'hABCD || bus.infifo_last !== 1'b1 || bus.level !== 5'd1) begin errors++; $display("FAIL mid_first dout=%h last=%b level=%0d exp=abcd,1,1", bus.infifo_dout, bus.infifo_last, bus.level); end
        cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [64:0] hw;
        int          n;
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                  {$urandom, $urandom}, ($urandom_range(0, 2) == 0) || (i > 200 && $urandom_range(0, 1) == 1),
                  ($urandom_range(0, 7) == 0));
            n  = mq.size();
            hw = (n == 0) ? 65'h0 : mq[0];
            checks++;
            if (bus.level !== 5'(n) || bus.infifo_is_empty !== (n == 0) || bus.s_axis_tready !== m_ready ||
                bus.infifo_almost_full !== (n >= AFULL) || bus.err_underflow !== m_err ||
                {bus.infifo_last, bus.infifo_dout} !== hw) begin
                errors++;
                $display("FAIL random i=%0d level=%0d/%0d empty=%b tready=%b/%b afull=%b err=%b/%b head=%h/%h",
                         i, bus.level, n, bus.infifo_is_empty, bus.s_axis_tready, m_ready,
                         bus.infifo_almost_full, bus.err_underflow, m_err, {bus.infifo_last, bus.infifo_dout}, hw);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.infifo_read   = 1'b0;
        bus.err_clear     = 1'b0;
        m_ready = 1'b0;
        m_err   = 1'b0;
        #1;
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
